// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/refresh arbiter with divide sequencing
// Optional macro DIV_STALL_EN: multi-cycle divider FSM; undefined means a single-cycle divider.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_rs_ren,
  input  logic       id_rt_ren,
  input  logic [5:0] id_rs,
  input  logic [5:0] id_rt,
  input  logic       ex_load,
  input  logic       ex_regwen,
  input  logic [5:0] ex_wreg,
  input  logic       ex_div,
  input  logic       inst_req,
  input  logic       inst_ok,
  input  logic       data_req,
  input  logic       data_ok,
  input  logic       mem_exc,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       memwb_stall,
  output logic       ifid_refresh,
  output logic       idex_refresh,
  output logic       exmem_refresh,
  output logic       memwb_refresh,
  output logic       div_busy,
  output logic       div_done
);

  logic data_st;
  logic div_st;
  logic lu_st;
  logic if_st;

  assign data_st = data_req & ~data_ok;
  assign if_st   = inst_req & ~inst_ok;
  assign lu_st   = ex_load & ex_regwen & (ex_wreg != 6'd0) &
                   ((id_rs_ren & (id_rs == ex_wreg)) | (id_rt_ren & (id_rt == ex_wreg)));

`ifdef DIV_STALL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 2);

  div_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A winning memory stall holds the divider exactly where it is, so no divide cycle is lost.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (mem_exc) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 6'd0;
    end else if (!data_st) begin
      case (state)
        S_IDLE: begin
          if (ex_div) begin
            state_nxt = S_DIV;
            cnt_nxt   = CNT_INIT;
          end
        end
        S_DIV: begin
          if (cnt != 6'd0) cnt_nxt = cnt - 6'd1;
          else state_nxt = S_DONE;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign div_st   = ((state == S_IDLE) & ex_div) | (state == S_DIV);
  assign div_busy = (state == S_DIV);
  assign div_done = (state == S_DONE) & ~mem_exc;
`else
  logic unused_cfg;

  assign unused_cfg = ^{clk, 6'(DIV_CYCLES)};
  assign div_st     = 1'b0;
  assign div_busy   = 1'b0;
  assign div_done   = resetn & ex_div & ~data_st & ~mem_exc;
`endif

  // Only the highest-priority source drives the outputs; each stalls upstream, bubbles downstream.
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idex_stall    = 1'b0;
    exmem_stall   = 1'b0;
    memwb_stall   = 1'b0;
    ifid_refresh  = 1'b0;
    idex_refresh  = 1'b0;
    exmem_refresh = 1'b0;
    memwb_refresh = 1'b0;
    if (!resetn) begin
      ifid_refresh  = 1'b1;
      idex_refresh  = 1'b1;
      exmem_refresh = 1'b1;
      memwb_refresh = 1'b1;
    end else if (mem_exc) begin
      ifid_refresh  = 1'b1;
      idex_refresh  = 1'b1;
      exmem_refresh = 1'b1;
    end else if (data_st) begin
      pc_stall      = 1'b1;
      ifid_stall    = 1'b1;
      idex_stall    = 1'b1;
      exmem_stall   = 1'b1;
      memwb_refresh = 1'b1;
    end else if (div_st) begin
      pc_stall      = 1'b1;
      ifid_stall    = 1'b1;
      idex_stall    = 1'b1;
      exmem_refresh = 1'b1;
    end else if (lu_st) begin
      pc_stall      = 1'b1;
      ifid_stall    = 1'b1;
      idex_refresh  = 1'b1;
    end else if (if_st) begin
      pc_stall      = 1'b1;
      ifid_refresh  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int DIVC = 33;

  // {pc, ifid_st, idex_st, exmem_st, memwb_st, ifid_rf, idex_rf, exmem_rf, memwb_rf, busy, done}
  localparam logic [10:0] E_NONE = 11'b00000_0000_00;
  localparam logic [10:0] E_RST  = 11'b00000_1111_00;
  localparam logic [10:0] E_IF   = 11'b10000_1000_00;
  localparam logic [10:0] E_LU   = 11'b11000_0100_00;
  localparam logic [10:0] E_DIV  = 11'b11100_0010_00;
  localparam logic [10:0] E_DATA = 11'b11110_0001_00;
  localparam logic [10:0] E_EXC  = 11'b00000_1110_00;
  localparam logic [10:0] E_DONE = 11'b00000_0000_01;
  localparam logic [10:0] BUSY   = 11'b00000_0000_10;

  logic       clk = 1'b0;
  logic       resetn;
  logic       id_rs_ren, id_rt_ren;
  logic [5:0] id_rs, id_rt;
  logic       ex_load, ex_regwen;
  logic [5:0] ex_wreg;
  logic       ex_div;
  logic       inst_req, inst_ok, data_req, data_ok, mem_exc;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic       ifid_refresh, idex_refresh, exmem_refresh, memwb_refresh;
  logic       div_busy, div_done;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren), .id_rs(id_rs), .id_rt(id_rt),
    .ex_load(ex_load), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg), .ex_div(ex_div),
    .inst_req(inst_req), .inst_ok(inst_ok), .data_req(data_req), .data_ok(data_ok),
    .mem_exc(mem_exc),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_refresh(ifid_refresh), .idex_refresh(idex_refresh),
    .exmem_refresh(exmem_refresh), .memwb_refresh(memwb_refresh),
    .div_busy(div_busy), .div_done(div_done)
  );

  assign obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                ifid_refresh, idex_refresh, exmem_refresh, memwb_refresh, div_busy, div_done};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string tag, input logic [10:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_now();
    logic [10:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %b with no expected entry", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", t, obs, e);
    end
  endtask

  task automatic step(input string tag, input logic [10:0] e);
    expect_out(tag, e);
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs_ren = 0; id_rt_ren = 0; id_rs = 0; id_rt = 0;
    ex_load = 0; ex_regwen = 0; ex_wreg = 0; ex_div = 0;
    inst_req = 0; inst_ok = 0; data_req = 0; data_ok = 0; mem_exc = 0;
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    step("reset_idle", E_RST);
    inst_req = 1; data_req = 1; ex_div = 1; mem_exc = 1;
    step("reset_busy_inputs", E_RST);
    idle_inputs();
    resetn = 1;
    step("idle", E_NONE);

    inst_req = 1;
    step("if_st_1", E_IF);
    step("if_st_2", E_IF);
    inst_ok = 1;
    step("if_ok", E_NONE);

    idle_inputs();
    ex_load = 1; ex_regwen = 1; ex_wreg = 5; id_rs_ren = 1; id_rs = 5;
    step("lu_rs", E_LU);
    ex_load = 0;
    step("lu_cleared", E_NONE);
    ex_load = 1; ex_wreg = 0; id_rs = 0;
    step("lu_wreg0", E_NONE);
    id_rs_ren = 0; id_rt_ren = 1; id_rt = 7; ex_wreg = 7;
    step("lu_rt", E_LU);
    id_rt_ren = 0;
    step("lu_rt_noren", E_NONE);
    id_rt_ren = 1; ex_regwen = 0;
    step("lu_noregwen", E_NONE);
    ex_regwen = 1; inst_req = 1;
    step("lu_over_if", E_LU);

    data_req = 1;
    step("data_over_lu_if", E_DATA);
    idle_inputs();
    data_req = 1;
    step("data_only", E_DATA);
    data_ok = 1;
    step("data_ok", E_NONE);
    data_ok = 0; inst_req = 1;
    mem_exc = 1;
    step("exc_over_all", E_EXC);
    idle_inputs();
    step("after_exc", E_NONE);

`ifdef DIV_STALL_EN
    ex_div = 1;
    step("div_idle_stall", E_DIV);
    for (int i = 0; i < DIVC - 1; i++) step("div_busy_stall", E_DIV | BUSY);
    step("div_done", E_DONE);
    ex_div = 0;
    step("div_no_restart", E_NONE);

    ex_div = 1;
    step("div2_idle_stall", E_DIV);
    for (int i = 0; i < 8; i++) step("div2_busy_stall", E_DIV | BUSY);
    data_req = 1;
    for (int i = 0; i < 3; i++) step("div2_data_freeze", E_DATA | BUSY);
    data_ok = 1;
    for (int i = 0; i < DIVC - 9; i++) step("div2_resume", E_DIV | BUSY);
    data_req = 0; data_ok = 0;
    step("div2_done", E_DONE);
    ex_div = 0;
    step("div2_after", E_NONE);

    ex_div = 1;
    step("div3_idle_stall", E_DIV);
    for (int i = 0; i < 4; i++) step("div3_busy_stall", E_DIV | BUSY);
    mem_exc = 1; inst_req = 1;
    step("div3_exc", E_EXC | BUSY);
    mem_exc = 0; inst_req = 0;
    step("div3_back_to_idle", E_DIV);
    for (int i = 0; i < 2; i++) step("div4_busy_stall", E_DIV | BUSY);
    #2;
    resetn = 0;
    #1;
    expect_out("div4_async_reset", E_RST);
    compare_now();
    @(posedge clk);
    #1;
    idle_inputs();
    resetn = 1;
    step("div4_after_reset", E_NONE);
    step("div4_no_done", E_NONE);
`else
    ex_div = 1;
    step("div_single_cycle", E_DONE);
    data_req = 1;
    step("div_with_data_st", E_DATA);
    data_req = 0; mem_exc = 1; inst_req = 1;
    step("div_with_exc", E_EXC);
    mem_exc = 0; inst_req = 0; inst_ok = 0;
    ex_load = 1; ex_regwen = 1; ex_wreg = 3; id_rs_ren = 1; id_rs = 3;
    step("div_with_lu", E_LU | E_DONE);
    idle_inputs();
    ex_div = 1;
    #2;
    resetn = 0;
    #1;
    expect_out("div_async_reset", E_RST);
    compare_now();
    @(posedge clk);
    #1;
    idle_inputs();
    resetn = 1;
    step("after_reset", E_NONE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
